sync_fifo_prog: RTL and testbench

Single-clock, parametrised FIFO, the successor to the team's dual-clock FIFO for paths where producer and consumer share one clock. Adds what the dual-clock part lacks: a runtime-programmable almost-full and almost-empty threshold, an exact fill count, a selectable standard or first-word-fall-through read mode, overflow and underflow pulses, and a synchronous flush. Pointers are plain binary; there are no synchronisers.

---
 rtl/fifo_pkg.sv | 10 +
 rtl/sync_fifo_mem.sv | 24 ++
 rtl/sync_fifo_prog.sv | 110 +++++++++++
 tb/tb_sync_fifo_prog.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared types and helpers for the single-clock programmable FIFO.
package fifo_pkg;

  typedef enum logic {FIFO_STD, FIFO_FWFT} fifo_mode_e;

  function automatic int ptr_w(input int asize);
    return asize + 1;
  endfunction

endpackage

// File: rtl/sync_fifo_mem.sv
// FIFO storage: synchronous write port, asynchronous read port, no reset.
module sync_fifo_mem #(
  parameter int DSIZE = 8,
  parameter int ASIZE = 6
) (
  input  logic             clk,
  input  logic             we,
  input  logic [ASIZE-1:0] waddr,
  input  logic [DSIZE-1:0] wdata,
  input  logic [ASIZE-1:0] raddr,
  output logic [DSIZE-1:0] rdata
);

  localparam int DEPTH = 1 << ASIZE;

  logic [DSIZE-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/sync_fifo_prog.sv
// Single-clock FIFO with programmable thresholds, exact fill count,
// standard or first-word-fall-through read mode, status pulses and flush.
module sync_fifo_prog
  import fifo_pkg::*;
#(
  parameter int DSIZE = 8,
  parameter int ASIZE = 6,
  parameter int FWFT  = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [DSIZE-1:0] wdata,
  input  logic             winc,
  input  logic             rinc,
  input  logic             flush,
  input  logic [ASIZE:0]   afull_thr,
  input  logic [ASIZE:0]   aempty_thr,
  output logic [DSIZE-1:0] rdata,
  output logic             wfull,
  output logic             rempty,
  output logic             walmost_full,
  output logic             ralmost_empty,
  output logic [ASIZE:0]   wcount,
  output logic             wr_ack,
  output logic             rd_valid,
  output logic             overflow,
  output logic             underflow
);

  localparam int PW    = ptr_w(ASIZE);
  localparam int DEPTH = 1 << ASIZE;

  logic [PW-1:0]    wptr, rptr, count;
  logic             wr_en, rd_en;
  logic [DSIZE-1:0] mem_rdata;

  // Extra pointer bit makes full (count == DEPTH) distinct from empty.
  assign count  = wptr - rptr;
  assign wfull  = (count == PW'(DEPTH));
  assign rempty = (count == '0);
  assign wcount = count;

  assign walmost_full  = (count >= afull_thr);
  assign ralmost_empty = (count <= aempty_thr);

  assign wr_en = winc && !wfull && !flush;
  assign rd_en = rinc && !rempty && !flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr <= '0;
      rptr <= '0;
    end else if (flush) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (wr_en) wptr <= wptr + 1'b1;
      if (rd_en) rptr <= rptr + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ack    <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      wr_ack    <= wr_en;
      overflow  <= winc && wfull && !flush;
      underflow <= rinc && rempty && !flush;
    end
  end

  sync_fifo_mem #(
    .DSIZE (DSIZE),
    .ASIZE (ASIZE)
  ) u_mem (
    .clk   (clk),
    .we    (wr_en),
    .waddr (wptr[ASIZE-1:0]),
    .wdata (wdata),
    .raddr (rptr[ASIZE-1:0]),
    .rdata (mem_rdata)
  );

  generate
    if (FWFT == int'(FIFO_FWFT)) begin : g_fwft
      // Gate the head word so an empty FIFO never exposes stale memory.
      assign rdata    = rempty ? '0 : mem_rdata;
      assign rd_valid = !rempty;
    end else begin : g_std
      logic [DSIZE-1:0] rdata_q;
      logic             rd_valid_q;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          rdata_q    <= '0;
          rd_valid_q <= 1'b0;
        end else begin
          rd_valid_q <= rd_en;
          if (rd_en) rdata_q <= mem_rdata;
        end
      end

      assign rdata    = rdata_q;
      assign rd_valid = rd_valid_q;
    end
  endgenerate

endmodule

// File: tb/tb_sync_fifo_prog.sv
// Directed bench: a standard-mode and an FWFT-mode FIFO share one stimulus stream.
module tb_sync_fifo_prog;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] wdata;
  logic       winc, rinc, flush;
  logic [4:0] afull_thr, aempty_thr;

  logic [7:0] s_rdata, f_rdata;
  logic       s_wfull, s_rempty, s_afull, s_aempty, s_ack, s_vld, s_ovf, s_unf;
  logic       f_wfull, f_rempty, f_afull, f_aempty, f_ack, f_vld, f_ovf, f_unf;
  logic [4:0] s_wcount, f_wcount;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sync_fifo_prog #(.DSIZE(8), .ASIZE(4), .FWFT(0)) u_std (
    .clk(clk), .rst_n(rst_n), .wdata(wdata), .winc(winc), .rinc(rinc), .flush(flush),
    .afull_thr(afull_thr), .aempty_thr(aempty_thr), .rdata(s_rdata), .wfull(s_wfull),
    .rempty(s_rempty), .walmost_full(s_afull), .ralmost_empty(s_aempty), .wcount(s_wcount),
    .wr_ack(s_ack), .rd_valid(s_vld), .overflow(s_ovf), .underflow(s_unf)
  );

  sync_fifo_prog #(.DSIZE(8), .ASIZE(4), .FWFT(1)) u_fwft (
    .clk(clk), .rst_n(rst_n), .wdata(wdata), .winc(winc), .rinc(rinc), .flush(flush),
    .afull_thr(afull_thr), .aempty_thr(aempty_thr), .rdata(f_rdata), .wfull(f_wfull),
    .rempty(f_rempty), .walmost_full(f_afull), .ralmost_empty(f_aempty), .wcount(f_wcount),
    .wr_ack(f_ack), .rd_valid(f_vld), .overflow(f_ovf), .underflow(f_unf)
  );

  typedef struct {
    logic       w, r, f;
    logic [7:0] d;
    logic [4:0] athr;
    int         cnt;
    logic       full, empty, afull, aempty, ack, ovf, unf;
    logic [7:0] srd;
    logic       svld;
    logic [7:0] frd;
    logic       fvld;
  } vec_t;

  vec_t vq[$];

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s (vec %0d): got %0h, expected %0h", name, idx, act, exp);
    end
  endtask

  // Expected flags follow from the hand-computed count: depth 16, aempty_thr 3.
  task automatic add(input logic w, r, f, input logic [7:0] d, input logic [4:0] athr,
                     input int cnt, input logic ack, ovf, unf,
                     input logic [7:0] srd, input logic svld, input logic [7:0] frd);
    vec_t v;
    v.w = w; v.r = r; v.f = f; v.d = d; v.athr = athr; v.cnt = cnt;
    v.full = (cnt == 16); v.empty = (cnt == 0);
    v.afull = (cnt >= int'(athr)); v.aempty = (cnt <= 3);
    v.ack = ack; v.ovf = ovf; v.unf = unf;
    v.srd = srd; v.svld = svld; v.frd = frd; v.fvld = (cnt != 0);
    vq.push_back(v);
  endtask

  int vec_idx = 0;

  task automatic apply_vecs();
    while (vq.size() > 0) begin
      vec_t v;
      v = vq.pop_front();
      winc = v.w; rinc = v.r; flush = v.f; wdata = v.d; afull_thr = v.athr;
      @(posedge clk);
      @(negedge clk);
      chk("wcount",        vec_idx, 32'(s_wcount), 32'(v.cnt));
      chk("fwft_wcount",   vec_idx, 32'(f_wcount), 32'(v.cnt));
      chk("wfull",         vec_idx, 32'(s_wfull),  32'(v.full));
      chk("rempty",        vec_idx, 32'(s_rempty), 32'(v.empty));
      chk("walmost_full",  vec_idx, 32'(s_afull),  32'(v.afull));
      chk("ralmost_empty", vec_idx, 32'(s_aempty), 32'(v.aempty));
      chk("wr_ack",        vec_idx, 32'(s_ack),    32'(v.ack));
      chk("overflow",      vec_idx, 32'(s_ovf),    32'(v.ovf));
      chk("underflow",     vec_idx, 32'(s_unf),    32'(v.unf));
      chk("std_rdata",     vec_idx, 32'(s_rdata),  32'(v.srd));
      chk("std_rd_valid",  vec_idx, 32'(s_vld),    32'(v.svld));
      chk("fwft_rd_valid", vec_idx, 32'(f_vld),    32'(v.fvld));
      if (v.fvld) chk("fwft_rdata", vec_idx, 32'(f_rdata), 32'(v.frd));
      vec_idx++;
    end
    winc = 1'b0; rinc = 1'b0; flush = 1'b0;
  endtask

  task automatic chk_reset_values(input string tag);
    chk({tag, "_wcount"},   0, 32'(s_wcount), 32'd0);
    chk({tag, "_rempty"},   0, 32'(s_rempty), 32'd1);
    chk({tag, "_wfull"},    0, 32'(s_wfull),  32'd0);
    chk({tag, "_aempty"},   0, 32'(s_aempty), 32'd1);
    chk({tag, "_afull"},    0, 32'(s_afull),  32'd0);
    chk({tag, "_ack"},      0, 32'(s_ack),    32'd0);
    chk({tag, "_ovf"},      0, 32'(s_ovf),    32'd0);
    chk({tag, "_unf"},      0, 32'(s_unf),    32'd0);
    chk({tag, "_srdata"},   0, 32'(s_rdata),  32'd0);
    chk({tag, "_svld"},     0, 32'(s_vld),    32'd0);
    chk({tag, "_frdata"},   0, 32'(f_rdata),  32'd0);
    chk({tag, "_fvld"},     0, 32'(f_vld),    32'd0);
    chk({tag, "_fwcount"},  0, 32'(f_wcount), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; winc = 1'b0; rinc = 1'b0; flush = 1'b0; wdata = 8'h00;
    afull_thr = 5'd12; aempty_thr = 5'd3;
    #1;
    chk_reset_values("reset");
    afull_thr = 5'd0;
    #1;
    chk("reset_afull_thr0", 0, 32'(s_afull), 32'd1);
    afull_thr = 5'd12;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Fill, overflow, simultaneous access while full, drain, underflow.
    for (int i = 0; i < 16; i++) add(1, 0, 0, 8'(i), 12, i + 1, 1, 0, 0, 8'h00, 0, 8'h00);
    add(1, 0, 0, 8'h10, 12, 16, 0, 1, 0, 8'h00, 0, 8'h00);
    add(0, 0, 0, 8'h00, 12, 16, 0, 0, 0, 8'h00, 0, 8'h00);
    add(1, 1, 0, 8'h20, 12, 15, 0, 1, 0, 8'h00, 1, 8'h01);
    for (int k = 1; k < 16; k++) add(0, 1, 0, 8'h00, 12, 15 - k, 0, 0, 0, 8'(k), 1, 8'(k + 1));
    add(0, 1, 0, 8'h00, 12, 0, 0, 0, 1, 8'h0F, 0, 8'h00);
    // Simultaneous access while empty, FWFT head visibility.
    add(1, 1, 0, 8'hA5, 12, 1, 1, 0, 1, 8'h0F, 0, 8'hA5);
    add(0, 1, 0, 8'h00, 12, 0, 0, 0, 0, 8'hA5, 1, 8'h00);
    add(1, 0, 0, 8'h5A, 12, 1, 1, 0, 0, 8'hA5, 0, 8'h5A);
    add(0, 0, 0, 8'h00, 12, 1, 0, 0, 0, 8'hA5, 0, 8'h5A);
    add(0, 1, 0, 8'h00, 12, 0, 0, 0, 0, 8'h5A, 1, 8'h00);
    // Half fill then 40 cycles of streaming across the pointer wrap.
    for (int i = 0; i < 8; i++) add(1, 0, 0, 8'(8'h40 + i), 12, i + 1, 1, 0, 0, 8'h5A, 0, 8'h40);
    for (int j = 0; j < 40; j++)
      add(1, 1, 0, 8'(8'h48 + j), 12, 8, 1, 0, 0, 8'(8'h40 + j), 1, 8'(8'h41 + j));
    add(1, 0, 0, 8'h70, 12, 9, 1, 0, 0, 8'h67, 0, 8'h68);
    add(1, 0, 0, 8'h71, 12, 10, 1, 0, 0, 8'h67, 0, 8'h68);
    apply_vecs();

    // Threshold inputs act combinationally, without waiting for an edge.
    chk("afull_at10_thr12", 0, 32'(s_afull), 32'd0);
    afull_thr = 5'd8;
    #1;
    chk("afull_at10_thr8", 0, 32'(s_afull), 32'd1);
    chk("fwft_afull_thr8", 0, 32'(f_afull), 32'd1);
    aempty_thr = 5'd10;
    #1;
    chk("aempty_at10_thr10", 0, 32'(s_aempty), 32'd1);
    afull_thr = 5'd12; aempty_thr = 5'd3;
    #1;
    chk("afull_restored", 0, 32'(s_afull), 32'd0);

    // Drop to 9, then flush with a write pending; afterwards storage restarts at 0.
    add(0, 1, 0, 8'h00, 12, 9, 0, 0, 0, 8'h68, 1, 8'h69);
    add(1, 1, 1, 8'hEE, 12, 0, 0, 0, 0, 8'h68, 0, 8'h00);
    add(1, 0, 0, 8'h77, 12, 1, 1, 0, 0, 8'h68, 0, 8'h77);
    add(1, 0, 0, 8'h78, 12, 2, 1, 0, 0, 8'h68, 0, 8'h77);
    apply_vecs();

    // Asynchronous reset between edges with a write in flight.
    winc = 1'b1; wdata = 8'h79;
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset_values("midrst");
    winc = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    add(1, 0, 0, 8'h99, 12, 1, 1, 0, 0, 8'h00, 0, 8'h99);
    add(0, 1, 0, 8'h00, 12, 0, 0, 0, 0, 8'h99, 1, 8'h00);
    apply_vecs();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
